evt_uart_logger: RTL and testbench
==================================

EVT_UART_LOGGER -- requirements
Module: evt_uart_logger

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per UART bit, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of event entries, a power of two, range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port evt_valid, input, 1 bit: one-cycle change-event strobe from the upstream change detector.
REQ-006 SHALL have port evt_chan, input, 2 bits: channel index of the event.
REQ-007 SHALL have port evt_data, input, 8 bits: new sample value of the event.
REQ-008 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-009 SHALL have port tx, output, 1 bit: UART 8N1 serial line, LSB first, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame sequence is being transmitted.
REQ-011 SHALL have port fifo_full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-013 SHALL have port fifo_count, output, 5 bits: current FIFO occupancy.

Function
REQ-014 SHALL push {evt_chan, evt_data} when evt_valid=1 and fifo_full=0; pushes are visible in fifo_count on the next cycle.
REQ-015 SHALL drop the event and set overflow when evt_valid=1 arrives while the FIFO is full and no pop occurs in the same cycle.
REQ-016 SHALL accept a push and a pop in the same cycle; at full, this leaves count unchanged and sets no overflow.
REQ-017 SHALL use the sequencer FSM states IDLE, START, DATA, STOP, with bit timing of CLKS_PER_BIT cycles each.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head entry into a holding register and enter START on the next cycle.
REQ-019 SHALL transmit per event a header byte {4'hA, 2'b00, chan} followed by a data byte equal to evt_data.
REQ-020 SHALL follow the frame order START -> DATA (8 bits) -> STOP, then START for the next byte of the same event, or IDLE after the last byte.
REQ-021 SHALL require exactly 10*CLKS_PER_BIT cycles per byte; tx SHALL fall to 0 one cycle after the pop.
REQ-022 SHALL hold busy high from the pop cycle+1 until the last STOP bit completes; busy SHALL be 0 in IDLE.
REQ-023 SHALL give ovf_clr priority over a simultaneous overflow set, clearing the flag.
REQ-024 SHALL wrap the FIFO pointers modulo FIFO_DEPTH with no loss or duplication of entries.

Reset
REQ-025 SHALL, on rst_n=0 and asynchronously, force tx=1, busy=0, fifo_full=0, overflow=0, fifo_count=0, FSM=IDLE, and empty the FIFO.
REQ-026 SHALL abort a frame in progress on reset without emitting further bits; the line returns high immediately.

Configuration
REQ-027 SHALL, when the macro EVT_UART_TIMESTAMP_EN is defined, keep a free-running 8-bit cycle/CLKS_PER_BIT tick counter (reset 0, wraps 255->0), store it with each push, and send it as a third byte after the data byte.
REQ-028 SHALL, when EVT_UART_TIMESTAMP_EN is undefined, omit the counter and the FIFO timestamp field and send two bytes per event.

Structure
REQ-029 SHALL place in shared package evt_uart_pkg: the FSM state enum, the header-nibble constant HDR_NIBBLE=4'hA, and the entry-width constant (10, or 18 with the timestamp).
REQ-030 SHALL implement the bit-level shifter and baud counter as sub-module evt_uart_tx_byte, with a load/ready handshake.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single event chan=2, data=8'h5C -> tx carries 0xA2 then 0x5C, 80 cycles total, then busy=0.
REQ-032 Five evt_valid pulses on consecutive cycles from empty -> four entries stored (one popped immediately, then 3 queued plus one more); the fifth pulse either lands or sets overflow exactly per REQ-015/016; check fifo_count each cycle.
REQ-033 Overflow set, then ovf_clr pulse coinciding with another dropped event -> overflow=0 afterward.
REQ-034 rst_n asserted mid-DATA of the header byte -> tx=1 and fifo_count=0 in the same cycle; no further falling edges on tx.
REQ-035 Twenty events streamed at a rate of one per 80 cycles -> pointers wrap; byte stream matches the issue order with no loss.
REQ-036 With EVT_UART_TIMESTAMP_EN defined, two events 40 cycles apart -> third bytes differ by 10.

Source files
------------

// File: rtl/evt_uart_pkg.sv
// Shared types and constants for the event UART logger.
// Build option EVT_UART_TIMESTAMP_EN adds an 8-bit timestamp to every entry and a third byte per event.
package evt_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;

`ifdef EVT_UART_TIMESTAMP_EN
    localparam int         ENTRY_W   = 18;
    localparam logic [1:0] NUM_BYTES = 2'd3;

    typedef struct packed {
        logic [7:0] ts;
        logic [1:0] chan;
        logic [7:0] data;
    } evt_entry_t;
`else
    localparam int         ENTRY_W   = 10;
    localparam logic [1:0] NUM_BYTES = 2'd2;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } evt_entry_t;
`endif

    function automatic logic [7:0] hdr_byte(input logic [1:0] chan);
        return {HDR_NIBBLE, 2'b00, chan};
    endfunction

endpackage

// File: rtl/evt_uart_logger_if.sv
// Event bus from the upstream change detector into the logger.
interface evt_uart_logger_if;
    logic       evt_valid;
    logic [1:0] evt_chan;
    logic [7:0] evt_data;

    modport master (output evt_valid, output evt_chan, output evt_data);
    modport slave  (input  evt_valid, input  evt_chan, input  evt_data);
endinterface

// File: rtl/evt_uart_tx_byte.sv
// 8N1 byte serialiser with its own baud counter; ready_o also rises in the last STOP cycle so
// back-to-back bytes follow each other with no idle gap.
module evt_uart_tx_byte
    import evt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    tx_state_t  state_q;
    logic [7:0] baud_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;
    logic       tx_q;
    logic       bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
    assign tx_o    = tx_q;

    // NOTE: every register in a clocked block is updated with <= so all of them see the
    // pre-edge values of each other, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            baud_q <= ((state_q == ST_IDLE) || bit_end) ? '0 : baud_q + 8'd1;
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        state_q <= ST_START;
                        shift_q <= byte_i;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (load_i) begin
                            state_q <= ST_START;
                            shift_q <= byte_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/evt_uart_logger.sv
// Change-event logger: FIFO of {chan, data} entries drained as header+data UART frames.
// Build option EVT_UART_TIMESTAMP_EN stores a tick timestamp per entry and sends it as a third byte.
module evt_uart_logger
    import evt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    evt_uart_logger_if.slave   evt,
    input  logic               ovf_clr,
    output logic               tx,
    output logic               busy,
    output logic               fifo_full,
    output logic               overflow,
    output logic [4:0]         fifo_count
);

    localparam int         PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [4:0]         count_q;
    logic               ovf_q;
    logic               busy_q;
    logic [1:0]         byte_idx_q;
    logic [7:0]         hold_data_q;

    evt_entry_t head;
    evt_entry_t push_entry;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;
    logic       byte_ready;
    logic       byte_load;
    logic [7:0] byte_val;

`ifdef EVT_UART_TIMESTAMP_EN
    logic [7:0] presc_q;
    logic [7:0] ts_q;
    logic [7:0] hold_ts_q;

    // Free-running tick: one increment every CLKS_PER_BIT cycles, wrapping at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ts_q    <= '0;
        end else if (presc_q == 8'(CLKS_PER_BIT - 1)) begin
            presc_q <= '0;
            ts_q    <= ts_q + 8'd1;
        end else begin
            presc_q <= presc_q + 8'd1;
        end
    end
`endif

    // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        push_entry      = '0;
        push_entry.chan = evt.evt_chan;
        push_entry.data = evt.evt_data;
`ifdef EVT_UART_TIMESTAMP_EN
        push_entry.ts   = ts_q;
`endif
        head = evt_entry_t'(mem_q[rd_ptr_q]);
    end

    // A pop frees a slot in the same cycle, so a push at full is accepted when a pop coincides.
    assign full = (count_q == DEPTH);
    assign pop  = !busy_q && (count_q != '0);
    assign push = evt.evt_valid && (!full || pop);
    assign drop = evt.evt_valid && full && !pop;

    // NOTE: the storage array has no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
            if (ovf_clr)   ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    // Sequencer: the header goes straight from the FIFO head at the pop; later bytes come from hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            byte_idx_q  <= '0;
            hold_data_q <= '0;
`ifdef EVT_UART_TIMESTAMP_EN
            hold_ts_q   <= '0;
`endif
        end else if (pop) begin
            busy_q      <= 1'b1;
            byte_idx_q  <= 2'd1;
            hold_data_q <= head.data;
`ifdef EVT_UART_TIMESTAMP_EN
            hold_ts_q   <= head.ts;
`endif
        end else if (busy_q && byte_ready) begin
            if (byte_idx_q == NUM_BYTES) busy_q <= 1'b0;
            else                         byte_idx_q <= byte_idx_q + 2'd1;
        end
    end

    always_comb begin
        byte_load = 1'b0;
        byte_val  = hdr_byte(head.chan);
        if (pop) begin
            byte_load = 1'b1;
        end else if (busy_q && byte_ready && (byte_idx_q != NUM_BYTES)) begin
            byte_load = 1'b1;
`ifdef EVT_UART_TIMESTAMP_EN
            byte_val  = (byte_idx_q == 2'd1) ? hold_data_q : hold_ts_q;
`else
            byte_val  = hold_data_q;
`endif
        end
    end

    evt_uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (byte_load),
        .byte_i  (byte_val),
        .ready_o (byte_ready),
        .tx_o    (tx)
    );

    assign busy       = busy_q;
    assign fifo_full  = full;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_evt_uart_logger.sv
// Bench for evt_uart_logger: queue-based behavioural model checked every cycle, a UART
// receiver for the byte stream, and directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_evt_uart_logger;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef EVT_UART_TIMESTAMP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int SEQ_CYC = NB * 10 * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;
    logic [4:0] fifo_count;

    evt_uart_logger_if evt_bus();

    evt_uart_logger #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt        (evt_bus),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
        logic [7:0] ts;
    } ev_t;

    ev_t        m_q[$];
    logic       m_ovf   = 1'b0;
    int         m_left  = 0;
    int         m_edges = 0;
    logic [7:0] m_bytes[3];

    initial begin : model
        logic was_idle;
        logic full_b;
        logic do_pop;
        ev_t  e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_ovf   = 1'b0;
                m_left  = 0;
                m_edges = 0;
            end else begin
                was_idle = (m_left == 0);
                if (!was_idle) m_left--;
                full_b = (m_q.size() == DEPTH);
                do_pop = was_idle && (m_q.size() > 0);
                if (do_pop) begin
                    e          = m_q.pop_front();
                    m_bytes[0] = {4'hA, 2'b00, e.chan};
                    m_bytes[1] = e.data;
                    m_bytes[2] = e.ts;
                    m_left     = SEQ_CYC;
                end
                if (evt_bus.evt_valid === 1'b1) begin
                    if (!full_b || do_pop) begin
                        e.chan = evt_bus.evt_chan;
                        e.data = evt_bus.evt_data;
                        e.ts   = 8'((m_edges / CPB) % 256);
                        m_q.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (ovf_clr) m_ovf = 1'b0;
                m_edges++;
            end
        end
    end

    function automatic logic exp_tx();
        int el;
        int bp;
        int w;
        if (m_left == 0) return 1'b1;
        el = SEQ_CYC - m_left;
        bp = el / CPB;
        w  = bp % 10;
        if (w == 0) return 1'b0;
        if (w == 9) return 1'b1;
        return m_bytes[bp / 10][w - 1];
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("cyc_tx",    tx,         exp_tx());
            check("cyc_busy",  busy,       m_left > 0);
            check("cyc_full",  fifo_full,  m_q.size() == DEPTH);
            check("cyc_ovf",   overflow,   m_ovf);
            check("cyc_count", fifo_count, m_q.size());
        end
    end

    // ---------------- UART receiver and edge monitor ----------------
    logic [7:0] rx_q[$];
    int         fall_cnt = 0;

    initial begin : rx
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : falls
        forever begin
            @(negedge tx);
            fall_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d, input logic clr);
        evt_bus.evt_valid = v;
        evt_bus.evt_chan  = ch;
        evt_bus.evt_data  = d;
        ovf_clr           = clr;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(busy === 1'b0 && fifo_count === 5'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", n < budget, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stream(input string name, input int mark,
                                input logic [1:0] chans[], input logic [7:0] datas[]);
        check({name, "_len"}, rx_q.size() - mark, chans.size() * NB);
        if (rx_q.size() - mark == chans.size() * NB) begin
            for (int j = 0; j < chans.size(); j++) begin
                check($sformatf("%s_hdr%0d", name, j), rx_q[mark + j * NB], {4'hA, 2'b00, chans[j]});
                check($sformatf("%s_dat%0d", name, j), rx_q[mark + j * NB + 1], datas[j]);
            end
        end
    endtask

    int         exp5[5] = '{1, 1, 2, 3, 4};
    logic [1:0] st_chan[];
    logic [7:0] st_data[];

    initial begin : main
        int mark;
        int bc;
        int n;
        int falls_before;

        drive(1'b0, 2'd0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_tx",       tx,         1'b1);
        check("rst_busy",     busy,       1'b0);
        check("rst_full",     fifo_full,  1'b0);
        check("rst_ovf",      overflow,   1'b0);
        check("rst_count",    fifo_count, 5'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single event: pop the cycle after the push, start bit one cycle after the pop.
        mark = rx_q.size();
        drive(1'b1, 2'd2, 8'h5C, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        check("t1_count_after_push", fifo_count, 5'd1);
        check("t1_tx_before_pop",    tx,         1'b1);
        check("t1_busy_before_pop",  busy,       1'b0);
        @(negedge clk);
        check("t1_tx_start",         tx,         1'b0);
        check("t1_busy_after_pop",   busy,       1'b1);
        check("t1_count_after_pop",  fifo_count, 5'd0);
        bc = 1;
        n  = 0;
        while (n < 500) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) bc++;
            else break;
        end
        check("t1_busy_cycles", bc, NB * 40);
        wait_idle(200);
        st_chan = '{2'd2};
        st_data = '{8'h5C};
        check_stream("t1", mark, st_chan, st_data);

        // Five back-to-back events from empty, then drops while full.
        mark = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'(i), 8'h10 + 8'(i), 1'b0);
            @(negedge clk);
            check($sformatf("burst_count%0d", i), fifo_count, exp5[i]);
        end
        check("burst_full", fifo_full, 1'b1);
        check("burst_ovf",  overflow,  1'b0);
        drive(1'b1, 2'd1, 8'hEE, 1'b0);
        @(negedge clk);
        check("drop_ovf",   overflow,   1'b1);
        check("drop_count", fifo_count, 5'd4);
        drive(1'b1, 2'd1, 8'hEF, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        check("clr_wins_ovf", overflow,   1'b0);
        check("clr_count",    fifo_count, 5'd4);

        // Push coinciding with the pop at full.
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy_low_timeout", n < 200, 1'b1);
        check("full_idle_count", fifo_count, 5'd4);
        drive(1'b1, 2'd3, 8'h77, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        check("pushpop_count", fifo_count, 5'd4);
        check("pushpop_ovf",   overflow,   1'b0);
        check("pushpop_busy",  busy,       1'b1);
        wait_idle(1000);
        st_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
        st_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h77};
        check_stream("burst", mark, st_chan, st_data);

        // Twenty events paced one per 80 cycles: pointers wrap several times.
        mark = rx_q.size();
        st_chan = new[20];
        st_data = new[20];
        for (int i = 0; i < 20; i++) begin
            st_chan[i] = 2'(i % 4);
            st_data[i] = 8'h30 + 8'(7 * i);
            drive(1'b1, st_chan[i], st_data[i], 1'b0);
            @(negedge clk);
            drive(1'b0, 2'd0, 8'h00, 1'b0);
            repeat (79) @(negedge clk);
        end
        wait_idle(2000);
        check_stream("stream", mark, st_chan, st_data);

`ifdef EVT_UART_TIMESTAMP_EN
        // Two events 40 cycles apart: timestamps differ by 40/CPB = 10 ticks.
        mark = rx_q.size();
        drive(1'b1, 2'd0, 8'h01, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        repeat (39) @(negedge clk);
        drive(1'b1, 2'd1, 8'h02, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        wait_idle(500);
        check("ts_len", rx_q.size() - mark, 6);
        if (rx_q.size() - mark == 6)
            check("ts_delta", 8'(rx_q[mark + 5] - rx_q[mark + 2]), 8'd10);
`endif

        // Reset in the middle of the header's data bits while tx is low.
        drive(1'b1, 2'd0, 8'h00, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'd1, 8'h01, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'd2, 8'h02, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_tx",    tx,         1'b0);
        check("pre_reset_busy",  busy,       1'b1);
        check("pre_reset_count", fifo_count, 5'd2);
        falls_before = fall_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx",    tx,         1'b1);
        check("async_rst_count", fifo_count, 5'd0);
        check("async_rst_busy",  busy,       1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("no_falls_after_reset", fall_cnt - falls_before, 0);
        check("post_reset_count",     fifo_count, 5'd0);
        check("post_reset_tx",        tx,         1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
